// File: rtl/mem_port_sequencer_if.sv
// Request/response and RAM-side bus of mem_port_sequencer.
// slave = sequencer view, master = requester/RAM view.
interface mem_port_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_rw;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_err;
    logic        busy;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done, dm_err, busy, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done, dm_err, busy, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one byte-wide 256-byte RAM between IF and data ports, one big-endian
// multi-beat request at a time. ARB_FAIR_EN selects round-robin arbitration.
module mem_port_sequencer (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t      state_q, state_d;
    logic        own_if_q, own_if_d;
    logic        rw_q, rw_d;
    logic        err_q, err_d;
    logic [7:0]  base_q, base_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] wsh_q, wsh_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        grant_any, grant_if;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:8], bus.if_addr[1:0], bus.dm_addr[31:8]};

    assign grant_any = bus.if_req | bus.dm_req;

`ifdef ARB_FAIR_EN
    // Last owner: 0 = data, 1 = IF. Under contention the other side wins.
    logic ptr_q, ptr_d;
    assign grant_if = bus.if_req & (~bus.dm_req | ~ptr_q);
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && grant_any) ptr_d = grant_if;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`else
    assign grant_if = bus.if_req & ~bus.dm_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            own_if_q <= 1'b0;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
            base_q   <= '0;
            last_q   <= '0;
            beat_q   <= '0;
            wsh_q    <= '0;
            rbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            own_if_q <= own_if_d;
            rw_q     <= rw_d;
            err_q    <= err_d;
            base_q   <= base_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            wsh_q    <= wsh_d;
            rbuf_q   <= rbuf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        own_if_d     = own_if_q;
        rw_d         = rw_q;
        err_d        = err_q;
        base_d       = base_q;
        last_d       = last_q;
        beat_d       = beat_q;
        wsh_d        = wsh_q;
        rbuf_d       = rbuf_q;
        bus.if_rdata = '0;
        bus.if_done  = 1'b0;
        bus.dm_rdata = '0;
        bus.dm_done  = 1'b0;
        bus.dm_err   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        bus.mem_we   = 1'b0;
        bus.busy     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    own_if_d = grant_if;
                    beat_d   = '0;
                    rbuf_d   = '0;
                    if (grant_if) begin
                        base_d = {bus.if_addr[7:2], 2'b00};
                        rw_d   = 1'b0;
                        err_d  = 1'b0;
                        last_d = 2'd3;
                        wsh_d  = '0;
                    end else begin
                        base_d = bus.dm_addr[7:0];
                        rw_d   = bus.dm_rw;
                        err_d  = (bus.dm_size == 2'b11);
                        // Write data is left-justified so each beat takes the top byte.
                        case (bus.dm_size)
                            2'b00: begin last_d = 2'd0; wsh_d = {bus.dm_wdata[7:0], 24'h0}; end
                            2'b01: begin last_d = 2'd1; wsh_d = {bus.dm_wdata[15:0], 16'h0}; end
                            2'b10: begin last_d = 2'd3; wsh_d = bus.dm_wdata; end
                            default: begin last_d = 2'd0; wsh_d = '0; end
                        endcase
                    end
                    state_d = (!grant_if && bus.dm_size == 2'b11) ? DONE : BEAT;
                end
            end
            BEAT: begin
                bus.mem_addr = base_q + {6'b0, beat_q};
                if (rw_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = wsh_q[31:24];
                    wsh_d         = {wsh_q[23:0], 8'h0};
                end else begin
                    // Shift-in leaves the first byte most significant, right-justified.
                    rbuf_d = {rbuf_q[23:0], bus.mem_rdata};
                end
                if (beat_q == last_q) state_d = DONE;
                else                  beat_d  = beat_q + 2'd1;
            end
            DONE: begin
                if (own_if_q) begin
                    bus.if_done  = 1'b1;
                    bus.if_rdata = rbuf_q;
                end else begin
                    bus.dm_done  = 1'b1;
                    bus.dm_err   = err_q;
                    bus.dm_rdata = rw_q ? 32'h0 : rbuf_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
